act_pipe: RTL and testbench
===========================

Name: act_pipe

Overview:
Multi-lane, mode-selectable activation stage that replaces the single-lane ReLU between the dense-layer accumulators and the next layer's input buffer. It applies pass-through, ReLU, leaky ReLU or clipped ReLU to LANES signed fixed-point values per beat. It has a 2-stage pipeline with full valid/ready backpressure. It also keeps a saturating count of lanes clamped to zero, which feeds the sparsity statistics register.

Parameters:
DATA_W, 16, signed lane width (two's complement).
LANES, 4, lanes per beat.
LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT via arithmetic right shift.
CNT_W, 32, width of the zero counter.

Ports:
clk  in  1  clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
in_data  in  LANES*DATA_W  packed input; lane i = [i*DATA_W +: DATA_W].
in_mode  in  2  0=PASS, 1=RELU, 2=LEAKY, 3=CLIP; sampled with each accepted beat.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
cfg_clip  in  DATA_W  signed clip ceiling for CLIP; quasi-static.
out_data  out  LANES*DATA_W  packed result, same lane layout.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
stat_clear  in  1  synchronous clear of zero_cnt.
zero_cnt  out  CNT_W  saturating count of output lanes forced to 0.

Behaviour:
- Reset (async, active-high): both stage valids = 0, out_valid = 0, out_data = 0, zero_cnt = 0. Pipeline contents are discarded mid-operation. in_ready = 1 once reset deasserts.
- Per-lane function, x signed:
  - PASS: y = x.
  - RELU: y = (x<0) ? 0 : x.
  - LEAKY: y = (x<0) ? x>>>LEAK_SHIFT : x. Rounds toward -inf, so -500 -> -63 and -1 -> -1.
  - CLIP: y = (x<0) ? 0 : min(x, cfg_clip). If cfg_clip<0, y = 0 for every lane.
- Output width is DATA_W. No result can overflow.
- "Zeroed" lane: a lane whose y was forced to 0 by the clamp. This covers RELU and CLIP with x<0, and every lane in CLIP when cfg_clip<0. A lane whose x==0 is not counted. PASS and LEAKY never count.
- Stage 1 registers: y per lane, plus a per-lane zeroed flag and s1_valid. Stage 2 is the output register (out_data, out_valid, zero count for the beat).
- Advance rules:
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || (s2 loads).
  - in_ready = !s1_valid || (!out_valid || out_ready). This is a combinational path from out_ready, which is allowed.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready stays 1. Sustained throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, out_data is held stable. s1 holds one more beat, then in_ready drops. No beat is lost or duplicated, and order is preserved.
- A beat is transferred on in_valid && in_ready (input) and on out_valid && out_ready (output).
- zero_cnt update on each output transfer: add popcount of that beat's zeroed flags, saturating at 2^CNT_W-1.
  - If stat_clear is high in the same cycle, clear wins: zero_cnt = 0 and the beat's count is dropped.
- cfg_clip is sampled at stage 1. Changing it mid-stream affects only beats entering stage 1 after the change.
- in_mode is carried per beat, so modes may differ beat to beat.

Decomposition:
- Shared package (nn_pkg): mode encodings MODE_PASS/RELU/LEAKY/CLIP, and the default DATA_W.
- One sub-module, act_lane: combinational per-lane function. Inputs x, mode, clip. Outputs y and the zeroed flag. It is instantiated LANES times in a generate loop.
- The popcount and the pipeline control stay in act_pipe.

Test Plan:
1. RELU, LANES=4, in = {1000, -500, 0, -32768}, out_ready=1 -> after 2 cycles out = {1000, 0, 0, 0}; zero_cnt = 2.
2. LEAKY, in = {-500, -1, 800, -8} -> out = {-63, -1, 800, -1}; zero_cnt unchanged.
3. CLIP, cfg_clip=600, in = {1000, 600, -5, 599} -> out = {600, 600, 0, 599}, zero_cnt += 1. Then cfg_clip=-1, in = {5, 5, 5, 5} -> out = {0, 0, 0, 0}, zero_cnt += 4.
4. Backpressure: stream 8 consecutive beats with out_ready low for cycles 3-7 -> in_ready falls after 2 beats are held, out_data is stable while stalled, and all 8 beats emerge in order with none lost.
5. Saturation and clear: force zero_cnt near max (CNT_W=4 build), send RELU beats of all negatives -> count stops at 15. Assert stat_clear coincident with an output transfer -> zero_cnt = 0.
6. Reset mid-stream: assert reset with both stages full -> out_valid = 0 and zero_cnt = 0 immediately (asynchronously). After release, in_ready = 1 and the next beat emerges after 2 cycles.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer datapath: activation mode encodings
// and the default lane width.
package nn_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLIP  = 2'd3
  } mode_e;

  localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/act_lane.sv
// Combinational activation for one signed lane; flags lanes that the clamp
// forced to zero so the pipeline can accumulate sparsity statistics.
module act_lane
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x,
  input  mode_e                    mode,
  input  logic signed [DATA_W-1:0] clip,
  output logic signed [DATA_W-1:0] y,
  output logic                     zeroed
);

  always_comb begin
    y      = x;
    zeroed = 1'b0;
    case (mode)
      MODE_PASS: ;
      MODE_RELU: begin
        if (x < 0) begin
          y      = '0;
          zeroed = 1'b1;
        end
      end
      MODE_LEAKY: begin
        if (x < 0) y = x >>> LEAK_SHIFT;
      end
      MODE_CLIP: begin
        // A negative ceiling clamps every lane, including x == 0.
        if ((clip < 0) || (x < 0)) begin
          y      = '0;
          zeroed = 1'b1;
        end else if (x > clip) begin
          y = clip;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// Multi-lane activation stage: per-lane function into stage 1, output register
// in stage 2, full valid/ready backpressure and a saturating zeroed-lane count.
module act_pipe
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       cfg_clip,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    stat_clear,
  output logic [CNT_W-1:0]        zero_cnt
);

  localparam int unsigned ZC_W = $clog2(LANES + 1);

  logic [LANES*DATA_W-1:0] lane_y;
  logic [LANES-1:0]        lane_zero;
  logic [LANES*DATA_W-1:0] s1_data;
  logic [LANES-1:0]        s1_zero;
  logic                    s1_valid;
  logic [ZC_W-1:0]         s1_pop;
  logic [ZC_W-1:0]         s2_zc;
  logic                    s1_ld;
  logic                    s2_ld;
  logic                    in_xfer;
  logic                    out_xfer;
  logic [CNT_W:0]          cnt_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_W     (DATA_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x      (in_data[i*DATA_W +: DATA_W]),
      .mode   (mode_e'(in_mode)),
      .clip   (cfg_clip),
      .y      (lane_y[i*DATA_W +: DATA_W]),
      .zeroed (lane_zero[i])
    );
  end

  assign s2_ld    = !out_valid || out_ready;
  assign s1_ld    = !s1_valid || s2_ld;
  assign in_ready = s1_ld;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    s1_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      s1_pop = s1_pop + ZC_W'(s1_zero[i]);
    end
  end

  // One extra bit catches the carry so saturation needs no separate compare.
  assign cnt_sum = {1'b0, zero_cnt} + (CNT_W+1)'(s2_zc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= '0;
    end else if (s1_ld) begin
      s1_valid <= in_valid;
      if (in_xfer) begin
        s1_data <= lane_y;
        s1_zero <= lane_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s2_zc     <= '0;
    end else if (s2_ld) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_data;
        s2_zc    <= s1_pop;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_cnt <= '0;
    end else if (stat_clear) begin
      zero_cnt <= '0;
    end else if (out_xfer) begin
      zero_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Scoreboard bench for act_pipe: directed activation cases, backpressure,
// async reset, counter saturation/clear, then randomized traffic.
module tb_act_pipe;

  localparam int W    = 16;
  localparam int L    = 4;
  localparam int LS   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [L*W-1:0] data;
    int             zc;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [L*W-1:0]      in_data;
  logic [1:0]          in_mode;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] cfg_clip;
  logic [L*W-1:0]      out_data;
  logic                out_valid;
  logic                out_ready;
  logic                stat_clear;
  logic [CW-1:0]       zero_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   accepted = 0;
  int   model_zc = 0;
  int   zc_add;
  bit   rand_done;

  act_pipe #(
    .DATA_W     (W),
    .LANES      (L),
    .LEAK_SHIFT (LS),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_clip   (cfg_clip),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stat_clear (stat_clear),
    .zero_cnt   (zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_lane(input int x, input int m, input int clip,
                                   output int y, output int z);
    y = x;
    z = 0;
    if (m == 1 && x < 0) begin
      y = 0;
      z = 1;
    end else if (m == 2 && x < 0) begin
      y = (x - ((1 << LS) - 1)) / (1 << LS);  // floor division
    end else if (m == 3) begin
      if (clip < 0 || x < 0) begin
        y = 0;
        z = 1;
      end else begin
        y = (x < clip) ? x : clip;
      end
    end
  endfunction

  function automatic exp_t make_exp(input logic [L*W-1:0] d, input int m, input int clip);
    exp_t e;
    logic signed [W-1:0] xs;
    int y, z;
    e.data = '0;
    e.zc   = 0;
    for (int i = 0; i < L; i++) begin
      xs = d[i*W +: W];
      ref_lane(int'(xs), m, clip, y, z);
      e.data[i*W +: W] = W'(y);
      e.zc += z;
    end
    return e;
  endfunction

  function automatic logic [L*W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [L*W-1:0] r;
    r[0*W +: W] = W'(a);
    r[1*W +: W] = W'(b);
    r[2*W +: W] = W'(c);
    r[3*W +: W] = W'(d);
    return r;
  endfunction

  function automatic int rand_lane();
    logic signed [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      2: return 0;
      3: return -1;
      4: return int'(cfg_clip);
      default: return int'(v);
    endcase
  endfunction

  function automatic logic [L*W-1:0] rand_beat();
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = W'(rand_lane());
    return r;
  endfunction

  // Enter and leave at posedge+1; expected result is queued at acceptance.
  task automatic send_beat(input logic [L*W-1:0] d, input logic [1:0] m);
    bit done;
    int guard;
    done = 0;
    guard = 0;
    in_data = d;
    in_mode = m;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(make_exp(d, int'(m), int'(cfg_clip)));
        accepted++;
        done = 1;
      end else if (++guard > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name);
    @(negedge clk);
    check({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "_lat2"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented beat with the queue head and tracks zero_cnt.
  always @(negedge clk) begin
    if (!reset) begin
      check("zero_cnt", 64'(zero_cnt), 64'(model_zc));
      zc_add = 0;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_unexpected actual=%0h required=no_beat", out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(q[0].data));
        end
        if (out_ready && q.size() != 0) begin
          zc_add = q[0].zc;
          void'(q.pop_front());
        end
      end
      if (stat_clear) model_zc = 0;
      else if (out_valid && out_ready)
        model_zc = (model_zc + zc_add > CMAX) ? CMAX : model_zc + zc_add;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset = 1'b1;
    in_data = '0;
    in_mode = 2'd0;
    in_valid = 1'b0;
    cfg_clip = '0;
    out_ready = 1'b1;
    stat_clear = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // RELU / LEAKY / CLIP directed beats
    send_beat(pack4(1000, -500, 0, -32768), 2'd1);
    check_latency("relu");
    send_beat(pack4(-500, -1, 800, -8), 2'd2);
    drain();
    cfg_clip = 16'sd600;
    send_beat(pack4(1000, 600, -5, 599), 2'd3);
    drain();
    cfg_clip = -16'sd1;
    send_beat(pack4(5, 5, 5, 5), 2'd3);
    drain();
    check("dir_zero_cnt", 64'(zero_cnt), 64'd7);

    // Async reset with both stages full
    out_ready = 1'b0;
    send_beat(pack4(-1, -2, -3, -4), 2'd1);
    send_beat(pack4(7, 8, 9, 10), 2'd0);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_zero_cnt", 64'(zero_cnt), 64'd0);
    q.delete();
    model_zc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cfg_clip = 16'sd300;
    send_beat(pack4(-100, 400, 200, 0), 2'd3);
    check_latency("post_rst");
    drain();

    // Eight back-to-back beats, output stalled for cycles 3-7
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(rand_beat(), 2'(i % 4));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Stalled output: exactly two beats are absorbed, then in_ready drops
    out_ready = 1'b0;
    a0 = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(rand_beat(), 2'd1);
      end
      begin
        repeat (6) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_held", 64'(accepted - a0), 64'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Saturation, then clear coincident with an output transfer
    for (int i = 0; i < 5; i++) send_beat(pack4(-1, -200, -32768, -7), 2'd1);
    drain();
    check("sat_zero_cnt", 64'(zero_cnt), 64'(CMAX));
    send_beat(pack4(-3, -3, -3, -3), 2'd1);
    @(posedge clk);
    #1;
    check("clr_out_valid", 64'(out_valid), 64'd1);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    check("clr_zero_cnt", 64'(zero_cnt), 64'd0);
    drain();

    // Randomized traffic
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
              0: cfg_clip = -16'sd1;
              1: cfg_clip = 16'sd0;
              2: cfg_clip = 16'sd32767;
              default: cfg_clip = W'($urandom_range(0, 20000));
            endcase
          end
          stat_clear = ($urandom_range(0, 19) == 0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_beat(rand_beat(), 2'($urandom_range(0, 3)));
        end
        stat_clear = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
